// File: rtl/subleq_core_if.sv
// Memory bus between the subleq core and its single-port synchronous RAM.
//   rw    : 1 = write cycle
//   addr  : word address
//   wdata : write data (RAM din)
//   rdata : read data (RAM dout), registered, reflects the previous cycle's addr
// master = core side, slave = RAM side.
interface subleq_core_if #(
    parameter int unsigned P_ADDR = 8,
    parameter int unsigned P_DATA = 8
) ();
    logic              rw;
    logic [P_ADDR-1:0] addr;
    logic [P_DATA-1:0] wdata;
    logic [P_DATA-1:0] rdata;

    modport master (output rw, output addr, output wdata, input rdata);
    modport slave  (input rw, input addr, input wdata, output rdata);
endinterface

// File: rtl/subleq_core.sv
// Subleq execution sequencer. Fetches A,B,C at pc, writes mem[B] = mem[B] - mem[A] and
// branches to C when the signed result is <= 0, otherwise advances pc by 3. A taken branch
// to all-ones halts the core. Every instruction takes 7 cycles (FA..WR).
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_run        : execute enable, sampled only in FA
//   mem          : RAM bus (master side), 1-cycle read latency
//   o_pc         : address of the current instruction
//   o_instr_done : 1-cycle pulse in WR
//   o_halted     : high in HALT
module subleq_core #(
    parameter int unsigned     P_ADDR     = 8,
    parameter int unsigned     P_DATA     = 8,
    parameter logic [P_ADDR-1:0] P_RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_run,
    subleq_core_if.master     mem,
    output logic [P_ADDR-1:0] o_pc,
    output logic              o_instr_done,
    output logic              o_halted
);

    typedef enum logic [2:0] {
        StFa, StFb, StFc, StRa, StRb, StEx, StWr, StHalt
    } state_e;

    state_e            r_state, w_state_d;
    logic [P_ADDR-1:0] r_pc, w_pc_d;
    logic [P_ADDR-1:0] r_op_a, r_op_b, r_op_c;
    logic [P_DATA-1:0] r_va, r_vb;

    logic [P_DATA-1:0] w_res;
    logic              w_taken;
    logic [P_ADDR-1:0] w_rd_addr;

    assign w_res     = r_vb - r_va;
    assign w_taken   = w_res[P_DATA-1] | (w_res == '0);
    assign w_rd_addr = mem.rdata[P_ADDR-1:0];

    // Next state and next pc.
    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        case (r_state)
            StFa:   if (i_run) w_state_d = StFb;
            StFb:   w_state_d = StFc;
            StFc:   w_state_d = StRa;
            StRa:   w_state_d = StRb;
            StRb:   w_state_d = StEx;
            StEx:   w_state_d = StWr;
            StWr: begin
                if (w_taken && (&r_op_c)) begin
                    w_state_d = StHalt;  // pc keeps pointing at the halting instruction
                end else begin
                    w_state_d = StFa;
                    w_pc_d    = w_taken ? r_op_c : r_pc + P_ADDR'(3);
                end
            end
            StHalt: w_state_d = StHalt;
            default: w_state_d = StFa;
        endcase
    end

    // Moore outputs: decoded from state and registers only, never from rdata.
    always_comb begin
        mem.rw       = 1'b0;
        mem.addr     = r_pc;
        mem.wdata    = '0;
        o_instr_done = 1'b0;
        o_halted     = 1'b0;
        case (r_state)
            StFb: mem.addr = r_pc + P_ADDR'(1);
            StFc: mem.addr = r_pc + P_ADDR'(2);
            StRa: mem.addr = r_op_a;
            StRb: mem.addr = r_op_b;
            StEx: mem.addr = r_op_b;
            StWr: begin
                mem.addr     = r_op_b;
                mem.rw       = 1'b1;
                mem.wdata    = w_res;
                o_instr_done = 1'b1;
            end
            StHalt: o_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFa;
            r_pc    <= P_RESET_PC;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_c  <= '0;
            r_va    <= '0;
            r_vb    <= '0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            // rdata lags addr by one cycle, so each capture takes the previous state's read.
            if (r_state == StFb) r_op_a <= w_rd_addr;
            if (r_state == StFc) r_op_b <= w_rd_addr;
            if (r_state == StRa) r_op_c <= w_rd_addr;
            if (r_state == StRb) r_va   <= mem.rdata;
            if (r_state == StEx) r_vb   <= mem.rdata;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: tb/tb_subleq_core.sv
// Bench for subleq_core: two cores (reset pc 0x00 and 0xFE), each with its own behavioural
// RAM. Expected writes go into per-core queues; a negedge monitor pops them on instr_done.
module tb_subleq_core;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wdata;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run0 = 1'b0;
    logic run1 = 1'b0;
    logic [7:0] pc0, pc1;
    logic done0, done1, halt0, halt1;

    logic       ld_clr = 1'b0;
    logic       ld_we = 1'b0;
    logic       ld_sel = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    wr_t q0[$];
    wr_t q1[$];
    int  rw_cnt0 = 0, rw_cnt1 = 0, done_cnt0 = 0;
    int  n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    subleq_core_if #(.P_ADDR(8), .P_DATA(8)) bus0 ();
    subleq_core_if #(.P_ADDR(8), .P_DATA(8)) bus1 ();

    subleq_core #(.P_ADDR(8), .P_DATA(8), .P_RESET_PC(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_run(run0), .mem(bus0),
        .o_pc(pc0), .o_instr_done(done0), .o_halted(halt0)
    );

    subleq_core #(.P_ADDR(8), .P_DATA(8), .P_RESET_PC(8'hFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_run(run1), .mem(bus1),
        .o_pc(pc1), .o_instr_done(done1), .o_halted(halt1)
    );

    // Single-port synchronous RAMs with a bench load port.
    always_ff @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 8'h00;
        end else if (ld_we && !ld_sel) begin
            mem0[ld_addr] <= ld_data;
        end else if (bus0.rw) begin
            mem0[bus0.addr] <= bus0.wdata;
        end
        bus0.rdata <= mem0[bus0.addr];
    end

    always_ff @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 8'h00;
        end else if (ld_we && ld_sel) begin
            mem1[ld_addr] <= ld_data;
        end else if (bus1.rw) begin
            mem1[bus1.addr] <= bus1.wdata;
        end
        bus1.rdata <= mem1[bus1.addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (bus0.rw) rw_cnt0++;
        if (bus1.rw) rw_cnt1++;
        if (done0) begin
            done_cnt0++;
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL sb0_unexpected: write addr=%0h data=%0h", bus0.addr, bus0.wdata);
            end else begin
                e = q0.pop_front();
                chk("sb0_addr", bus0.addr, e.addr);
                chk("sb0_wdata", bus0.wdata, e.wdata);
                chk("sb0_rw", bus0.rw, 1);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL sb1_unexpected: write addr=%0h data=%0h", bus1.addr, bus1.wdata);
            end else begin
                e = q1.pop_front();
                chk("sb1_addr", bus1.addr, e.addr);
                chk("sb1_wdata", bus1.wdata, e.wdata);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        run0  = 1'b0;
        run1  = 1'b0;
        ld_clr = 1'b1;
        @(posedge clk);
        #1 ld_clr = 1'b0;
    endtask

    task automatic ld(input logic sel, input logic [7:0] a, input logic [7:0] d);
        ld_sel = sel; ld_addr = a; ld_data = d; ld_we = 1'b1;
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulse run for one FA, then let the 7-cycle instruction finish; ends 1 unit after edge 7.
    task automatic run_instr0();
        @(negedge clk);
        run0 = 1'b1;
        @(posedge clk);
        #1 run0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic load_prog0(input logic [7:0] c, input logic [7:0] a9, input logic [7:0] a10);
        do_reset();
        ld(0, 8'h00, 8'h09); ld(0, 8'h01, 8'h0A); ld(0, 8'h02, c);
        ld(0, 8'h09, a9);    ld(0, 8'h0A, a10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rw_b, dn_b;

        // Basic subtract, not taken; second instruction at 3 for the reset test.
        load_prog0(8'h06, 8'h03, 8'h05);
        ld(0, 8'h03, 8'h09); ld(0, 8'h04, 8'h0A); ld(0, 8'h05, 8'h06);
        #1;
        chk("rst_rw", bus0.rw, 0);
        chk("rst_addr", bus0.addr, 8'h00);
        chk("rst_wdata", bus0.wdata, 8'h00);
        chk("rst_halted", halt0, 0);
        chk("rst_done", done0, 0);
        release_rst();
        rw_b = rw_cnt0; dn_b = done_cnt0;
        q0.push_back('{addr: 8'h0A, wdata: 8'h02});
        run_instr0();
        chk("t2_mem10", mem0[10], 8'h02);
        chk("t2_pc", pc0, 8'h03);
        chk("t2_done_pulses", done_cnt0 - dn_b, 1);
        chk("t2_rw_cycles", rw_cnt0 - rw_b, 1);
        chk("t2_idle_addr", bus0.addr, 8'h03);
        repeat (3) @(posedge clk);
        #1 chk("t2_idle_mem10", mem0[10], 8'h02);

        // Asynchronous reset during WR of the instruction at 3 (would write 0xFF).
        @(negedge clk);
        run0 = 1'b1;
        @(posedge clk);
        #1 run0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("t1_in_wr", bus0.rw, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_async_rw", bus0.rw, 0);
        chk("t1_async_addr", bus0.addr, 8'h00);
        chk("t1_async_pc", pc0, 8'h00);
        chk("t1_async_halted", halt0, 0);
        repeat (3) @(posedge clk);
        #1 chk("t1_no_write", mem0[10], 8'h02);

        // Zero result: branch taken.
        load_prog0(8'h06, 8'h05, 8'h05);
        release_rst();
        q0.push_back('{addr: 8'h0A, wdata: 8'h00});
        run_instr0();
        chk("t3_mem10", mem0[10], 8'h00);
        chk("t3_pc", pc0, 8'h06);

        // Signed wrap: 0x80 - 1 = 0x7F (positive, not taken).
        load_prog0(8'h06, 8'h01, 8'h80);
        release_rst();
        q0.push_back('{addr: 8'h0A, wdata: 8'h7F});
        run_instr0();
        chk("t4a_mem10", mem0[10], 8'h7F);
        chk("t4a_pc", pc0, 8'h03);

        // 0x00 - 1 = 0xFF (negative, taken).
        load_prog0(8'h06, 8'h01, 8'h00);
        release_rst();
        q0.push_back('{addr: 8'h0A, wdata: 8'hFF});
        run_instr0();
        chk("t4b_mem10", mem0[10], 8'hFF);
        chk("t4b_pc", pc0, 8'h06);

        // A == B with C = 0xFF: write 0 then halt.
        do_reset();
        ld(0, 8'h00, 8'h09); ld(0, 8'h01, 8'h09); ld(0, 8'h02, 8'hFF); ld(0, 8'h09, 8'h07);
        release_rst();
        q0.push_back('{addr: 8'h09, wdata: 8'h00});
        run_instr0();
        chk("t5_mem9", mem0[9], 8'h00);
        chk("t5_halted", halt0, 1);
        chk("t5_pc", pc0, 8'h00);
        rw_b = rw_cnt0;
        run0 = 1'b1;
        repeat (20) @(posedge clk);
        #1 run0 = 1'b0;
        chk("t5_rw_quiet", rw_cnt0 - rw_b, 0);
        chk("t5_still_halted", halt0, 1);
        chk("t5_halt_addr", bus0.addr, 8'h00);

        // Reset pc 0xFE: operand fetch wraps to 0x00; run=0 holds FA.
        do_reset();
        ld(1, 8'hFE, 8'h09); ld(1, 8'hFF, 8'h0A); ld(1, 8'h00, 8'h40);
        ld(1, 8'h09, 8'h01); ld(1, 8'h0A, 8'h01);
        release_rst();
        rw_b = rw_cnt1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_hold_rw", rw_cnt1 - rw_b, 0);
        chk("t6_hold_addr", bus1.addr, 8'hFE);
        chk("t6_hold_pc", pc1, 8'hFE);
        q1.push_back('{addr: 8'h0A, wdata: 8'h00});
        @(negedge clk);
        run1 = 1'b1;
        @(posedge clk);
        #1 run1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_pc", pc1, 8'h40);
        chk("t6_mem10", mem1[10], 8'h00);

        @(negedge clk);
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
